// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle for alu_multicycle.
// The master drives operands and start; the slave returns the registered results.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] ALUResultHi;
  logic             Zero;
  logic             Overflow;

  modport master (
    output start, ALUOperation, A, B,
    input  busy, done, ALUResult, ALUResultHi, Zero, Overflow
  );

  modport slave (
    input  start, ALUOperation, A, B,
    output busy, done, ALUResult, ALUResultHi, Zero, Overflow
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus a WIDTH-iteration
// shift-add unsigned multiplier, with a start/busy/done handshake.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  alu_multicycle_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [3:0] OpAnd      = 4'b0000;
  localparam logic [3:0] OpOr       = 4'b0001;
  localparam logic [3:0] OpNor      = 4'b0010;
  localparam logic [3:0] OpAdd      = 4'b0011;
  localparam logic [3:0] OpSub      = 4'b0100;
  localparam logic [3:0] OpSll      = 4'b0101;
  localparam logic [3:0] OpSrl      = 4'b0110;
  localparam logic [3:0] OpSlt      = 4'b0111;
  localparam logic [3:0] OpInc      = 4'b1001;
  localparam logic [3:0] OpMultPlus = 4'b1010;
  localparam logic [3:0] OpMul      = 4'b1011;

  typedef enum logic [0:0] {StIdle, StMult} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               plus_q, plus_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_final;
  logic               is_mul;

  // Single-cycle datapath straight from the live operands; only used when start is taken.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUOperation)
      OpAnd: alu_res = bus.A & bus.B;
      OpOr:  alu_res = bus.A | bus.B;
      OpNor: alu_res = ~(bus.A | bus.B);
      OpAdd: begin
        alu_res = bus.A + bus.B;
        alu_ovf = (bus.A[Msb] == bus.B[Msb]) && (alu_res[Msb] != bus.A[Msb]);
      end
      OpSub: begin
        alu_res = bus.A - bus.B;
        alu_ovf = (bus.A[Msb] != bus.B[Msb]) && (alu_res[Msb] != bus.A[Msb]);
      end
      OpSll: alu_res = bus.B << bus.A[SHW-1:0];
      OpSrl: alu_res = bus.B >> bus.A[SHW-1:0];
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OpInc: begin
        alu_res = bus.A + WIDTH'(1);
        alu_ovf = !bus.A[Msb] && alu_res[Msb];
      end
      default: ;
    endcase
  end

  assign is_mul     = (bus.ALUOperation == OpMul) || (bus.ALUOperation == OpMultPlus);
  assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
  // MULTPLUS increments the full product so the carry can ripple into the high half.
  assign prod_final = acc_step + {{(2*WIDTH-1){1'b0}}, plus_q};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    plus_d   = plus_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            plus_d   = (bus.ALUOperation == OpMultPlus);
            state_d  = StMult;
          end else begin
            res_d    = alu_res;
            res_hi_d = '0;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      StMult: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          res_d    = prod_final[WIDTH-1:0];
          res_hi_d = prod_final[2*WIDTH-1:WIDTH];
          zero_d   = (prod_final[WIDTH-1:0] == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      plus_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      plus_q   <= plus_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q == StMult);
  assign bus.done        = done_q;
  assign bus.ALUResult   = res_q;
  assign bus.ALUResultHi = res_hi_q;
  assign bus.Zero        = zero_q;
  assign bus.Overflow    = ovf_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8: vector table, random ops
// against an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus32();
  alu_multicycle_if #(.WIDTH(8))  bus8();

  alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Reference: signed overflow from out-of-range sums, products from wide integer multiply.
  function automatic void ref_op(input int w, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] lo,
                                 output logic [31:0] hi, output logic ovf);
    logic [63:0] mask, p;
    longint      sa, sb, s, smax, smin;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sh   = int'(a % 32'(w));
    p    = '0;
    s    = 0;
    hi   = '0;
    ovf  = 1'b0;
    case (op)
      4'h0: p = 64'(a & b);
      4'h1: p = 64'(a | b);
      4'h2: p = 64'(~(a | b));
      4'h3: begin p = 64'(a) + 64'(b); s = sa + sb; ovf = (s > smax) || (s < smin); end
      4'h4: begin p = 64'(a) - 64'(b); s = sa - sb; ovf = (s > smax) || (s < smin); end
      4'h5: p = 64'(b) << sh;
      4'h6: p = 64'(b) >> sh;
      4'h7: p = (sa < sb) ? 64'd1 : 64'd0;
      4'h9: begin p = 64'(a) + 64'd1; s = sa + 1; ovf = (s > smax) || (s < smin); end
      4'hA: begin p = 64'(a) * 64'(b) + 64'd1; hi = 32'((p >> w) & mask); end
      4'hB: begin p = 64'(a) * 64'(b); hi = 32'((p >> w) & mask); end
      default: p = '0;
    endcase
    lo = 32'(p & mask);
  endfunction

  // Called at posedge+#1 with busy=0; returns edges until done and busy cycles seen.
  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
    bus32.ALUOperation = op;
    bus32.A = a;
    bus32.B = b;
    bus32.start = 1'b1;
    lat = 0;
    bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      bus32.start = 1'b0;
      bus32.A = $urandom;
      bus32.B = $urandom;
      bus32.ALUOperation = 4'($urandom);
      if (bus32.busy) bcnt++;
      if (bus32.done) check("busy_at_done32", 64'(bus32.busy), 64'd0);
    end while (!bus32.done && lat < 100);
    if (!bus32.done) check("done_seen32", 64'(bus32.done), 64'd1);
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
    bus8.ALUOperation = op;
    bus8.A = a;
    bus8.B = b;
    bus8.start = 1'b1;
    lat = 0;
    bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      bus8.start = 1'b0;
      bus8.A = 8'($urandom);
      bus8.B = 8'($urandom);
      bus8.ALUOperation = 4'($urandom);
      if (bus8.busy) bcnt++;
      if (bus8.done) check("busy_at_done8", 64'(bus8.busy), 64'd0);
    end while (!bus8.done && lat < 100);
    if (!bus8.done) check("done_seen8", 64'(bus8.done), 64'd1);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, elo, ehi;
    logic        eovf;
    int          lat, bcnt, n, dcnt;
    logic [31:0] held;

    reset = 1'b0;
    bus32.start = 1'b0; bus32.ALUOperation = 4'h0; bus32.A = '0; bus32.B = '0;
    bus8.start  = 1'b0; bus8.ALUOperation  = 4'h0; bus8.A  = '0; bus8.B  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(bus32.busy), 64'd0);
    check("rst_done",  64'(bus32.done), 64'd0);
    check("rst_res",   64'(bus32.ALUResult), 64'd0);
    check("rst_hi",    64'(bus32.ALUResultHi), 64'd0);
    check("rst_zero",  64'(bus32.Zero), 64'd1);
    check("rst_ovf",   64'(bus32.Overflow), 64'd0);
    check("rst_zero8", 64'(bus8.Zero), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{4'h3, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1});
    tbl.push_back('{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{4'hF, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0, 1'b1, 1'b0, 1});
    tbl.push_back('{4'h5, 32'h0000001F, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{4'h4, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1});
    tbl.push_back('{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33});
    tbl.push_back('{4'hA, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 33});
    tbl.push_back('{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{4'h2, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{4'h6, 32'h00000004, 32'h80000000, 32'h08000000, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{4'h9, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h0, 1'b0, 1'b1, 1});
    tbl.push_back('{4'h4, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1});
    tbl.push_back('{4'hB, 32'h00012345, 32'h00000000, 32'h00000000, 32'h0, 1'b1, 1'b0, 33});
    tbl.push_back('{4'h1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0, 1'b1, 1'b0, 1});

    foreach (tbl[i]) begin
      issue32(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt);
      check($sformatf("tbl%0d_res", i),  64'(bus32.ALUResult),   64'(tbl[i].res));
      check($sformatf("tbl%0d_hi", i),   64'(bus32.ALUResultHi), 64'(tbl[i].hi));
      check($sformatf("tbl%0d_zero", i), 64'(bus32.Zero),        64'(tbl[i].zero));
      check($sformatf("tbl%0d_ovf", i),  64'(bus32.Overflow),    64'(tbl[i].ovf));
      check($sformatf("tbl%0d_lat", i),  64'(lat),               64'(tbl[i].lat));
      check($sformatf("tbl%0d_busy", i), 64'(bcnt),              64'(tbl[i].lat - 1));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_drop", i), 64'(bus32.done),      64'd0);
      check($sformatf("tbl%0d_hold", i),      64'(bus32.ALUResult), 64'(tbl[i].res));
    end

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      ref_op(32, op, a, b, elo, ehi, eovf);
      issue32(op, a, b, lat, bcnt);
      check($sformatf("rnd%0d_op%0h_res", i, op), 64'(bus32.ALUResult),   64'(elo));
      check($sformatf("rnd%0d_op%0h_hi", i, op),  64'(bus32.ALUResultHi), 64'(ehi));
      check($sformatf("rnd%0d_op%0h_zero", i, op), 64'(bus32.Zero),       64'(elo == '0));
      check($sformatf("rnd%0d_op%0h_ovf", i, op), 64'(bus32.Overflow),    64'(eovf));
      check($sformatf("rnd%0d_op%0h_lat", i, op), 64'(lat),
            (op == 4'hA || op == 4'hB) ? 64'd33 : 64'd1);
    end

    // Back-to-back single-cycle ops with start held high.
    bus32.start = 1'b1; bus32.ALUOperation = 4'h3; bus32.A = 32'd1; bus32.B = 32'd2;
    @(posedge clk); #1;
    check("b2b_add_done", 64'(bus32.done), 64'd1);
    check("b2b_add_res",  64'(bus32.ALUResult), 64'd3);
    bus32.ALUOperation = 4'h1; bus32.A = 32'hF0; bus32.B = 32'h0F;
    @(posedge clk); #1;
    check("b2b_or_done", 64'(bus32.done), 64'd1);
    check("b2b_or_res",  64'(bus32.ALUResult), 64'hFF);
    bus32.ALUOperation = 4'h0; bus32.A = 32'hF0; bus32.B = 32'h3C;
    @(posedge clk); #1;
    check("b2b_and_res", 64'(bus32.ALUResult), 64'h30);
    bus32.start = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_done", 64'(bus32.done), 64'd0);
    check("b2b_idle_hold", 64'(bus32.ALUResult), 64'h30);

    // start during busy is ignored; a start on the done cycle is accepted.
    bus32.start = 1'b1; bus32.ALUOperation = 4'hB; bus32.A = 32'd6; bus32.B = 32'd7;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    n = 1;
    repeat (4) begin @(posedge clk); #1; n++; end
    bus32.start = 1'b1; bus32.ALUOperation = 4'h3; bus32.A = 32'd1; bus32.B = 32'd1;
    @(posedge clk); #1;
    n++;
    bus32.start = 1'b0;
    check("ign_busy", 64'(bus32.busy), 64'd1);
    check("ign_done", 64'(bus32.done), 64'd0);
    while (!bus32.done && n < 100) begin @(posedge clk); #1; n++; end
    check("ign_lat", 64'(n), 64'd33);
    check("ign_res", 64'(bus32.ALUResult), 64'd42);
    check("ign_hi",  64'(bus32.ALUResultHi), 64'd0);
    issue32(4'h3, 32'd1, 32'd1, lat, bcnt);
    check("donecyc_lat", 64'(lat), 64'd1);
    check("donecyc_res", 64'(bus32.ALUResult), 64'd2);

    // Reset in the middle of a multiply.
    held = bus32.ALUResult;
    bus32.start = 1'b1; bus32.ALUOperation = 4'hB; bus32.A = 32'd7; bus32.B = 32'd9;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mrst_busy", 64'(bus32.busy), 64'd0);
    check("mrst_res",  64'(bus32.ALUResult), 64'd0);
    check("mrst_zero", 64'(bus32.Zero), 64'd1);
    check("mrst_prev_nonzero", 64'(held != '0), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (bus32.done) dcnt++; end
    check("mrst_no_done", 64'(dcnt), 64'd0);
    check("mrst_res_after", 64'(bus32.ALUResult), 64'd0);

    // WIDTH=8 instance.
    issue8(4'hB, 8'hFF, 8'hFF, lat, bcnt);
    check("w8_mul_lo",   64'(bus8.ALUResult), 64'h01);
    check("w8_mul_hi",   64'(bus8.ALUResultHi), 64'hFE);
    check("w8_mul_lat",  64'(lat), 64'd9);
    check("w8_mul_busy", 64'(bcnt), 64'd8);
    issue8(4'hF, 8'd3, 8'd4, lat, bcnt);
    check("w8_undef_res",  64'(bus8.ALUResult), 64'd0);
    check("w8_undef_hi",   64'(bus8.ALUResultHi), 64'd0);
    check("w8_undef_zero", 64'(bus8.Zero), 64'd1);
    check("w8_undef_lat",  64'(lat), 64'd1);
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 32'(8'($urandom));
      b  = 32'(8'($urandom));
      ref_op(8, op, a, b, elo, ehi, eovf);
      issue8(op, a[7:0], b[7:0], lat, bcnt);
      check($sformatf("w8rnd%0d_op%0h_res", i, op), 64'(bus8.ALUResult),   64'(elo));
      check($sformatf("w8rnd%0d_op%0h_hi", i, op),  64'(bus8.ALUResultHi), 64'(ehi));
      check($sformatf("w8rnd%0d_op%0h_ovf", i, op), 64'(bus8.Overflow),    64'(eovf));
      check($sformatf("w8rnd%0d_op%0h_lat", i, op), 64'(lat),
            (op == 4'hA || op == 4'hB) ? 64'd9 : 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the datapath's single-cycle ALU. It keeps the existing 4-bit operation encoding, adds shift, set-less-than and an unsigned multiply, and runs multiplies as a WIDTH-iteration shift-add sequence. A start/busy/done handshake lets the control FSM stall while a multiply is in flight. It sits in the execute stage between the operand muxes and the result/branch logic.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch operation; sampled only when busy=0
- ALUOperation  in  4  operation code, sampled with start
- A  in  WIDTH  operand A, sampled with start
- B  in  WIDTH  operand B, sampled with start
- busy  out  1  multiply sequence in progress
- done  out  1  one-cycle pulse: result outputs updated this cycle
- ALUResult  out  WIDTH  result (low half for multiplies)
- ALUResultHi  out  WIDTH  high half of product; 0 for non-multiply ops
- Zero  out  1  registered (ALUResult == 0)
- Overflow  out  1  signed overflow for ADD/SUB/INC; 0 otherwise

## Operation
- Encodings: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SLL 0101 (B << A[SHW-1:0]), SRL 0110 (B >> A[SHW-1:0], logical), SLT 0111 (signed A<B → 1 else 0), INC 1001 (A+1), MULTPLUS 1010 (A*B+1), MUL 1011 (A*B). Any other code → result 0, Hi 0, Overflow 0.
- Arithmetic is modulo 2^WIDTH; Overflow = operands' sign bits agree (B inverted for SUB, 0 for INC) and result sign differs.
- Multiplies are unsigned, 2*WIDTH-bit product {ALUResultHi, ALUResult}; MULTPLUS adds 1 to the full 2*WIDTH product (carry propagates into Hi).
- FSM states: IDLE, MULT.
  - IDLE, start=1, single-cycle op: compute from sampled inputs, register all outputs, pulse done next cycle; stay IDLE.
  - IDLE, start=1, MUL/MULTPLUS: latch A, B, op; clear 2*WIDTH accumulator and iteration counter; busy=1; go MULT.
  - MULT: each cycle, if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left, multiplier right; increment counter. After WIDTH iterations, apply +1 if MULTPLUS, register outputs, pulse done, busy=0, return IDLE.
  - start while busy=1 is ignored (no queueing, no restart).
- Outputs hold their last value between operations; Zero/Overflow always refer to the held result.
- Reset (any state): return to IDLE, abort multiply, discard latched operands.

## Timing
- Reset values: busy 0, done 0, ALUResult 0, ALUResultHi 0, Zero 1, Overflow 0.
- Single-cycle ops: start at edge N → outputs valid and done=1 after edge N+1; back-to-back start each cycle gives one result per cycle.
- Multiplies: start at edge N → busy=1 after edge N+1 through edge N+WIDTH; after edge N+WIDTH+1 busy=0, done=1, outputs valid. Latency WIDTH+1 cycles, data-independent.
- start accepted in the cycle busy falls (done=1 cycle) since busy=0 then.
- done never high for two consecutive cycles from one operation; never asserted during busy.
- A/B/ALUOperation may change freely after the start cycle.

## Test plan
- Reset mid-multiply: start MUL A=7 B=9, assert reset at cycle 5 → busy 0, ALUResult 0, Zero 1 immediately; no done afterwards.
- Single-cycle ops (WIDTH=32): ADD 0x7FFFFFFF+1 → 0x80000000, Overflow 1; SUB 5-5 → 0, Zero 1; SLT A=0xFFFFFFFF B=1 → 1; SLL B=1 A=31 → 0x80000000; each done exactly one cycle after start.
- MUL A=0xFFFFFFFF B=0xFFFFFFFF → Hi 0xFFFFFFFE, Lo 0x00000001, done exactly 33 cycles after start, busy high 32 cycles.
- MULTPLUS A=0xFFFFFFFF B=1 → Hi 0x00000001, Lo 0x00000000, Zero 1 (carry into Hi).
- start pulsed during busy with ADD 1+1 → ignored; multiply result unchanged; ADD issued on done cycle → result 2 one cycle later.
- Undefined code 1111 with A=3 B=4 → ALUResult 0, Zero 1, done pulses after one cycle; repeat at WIDTH=8 with MUL 0xFF*0xFF → Hi 0xFE, Lo 0x01, latency 9.
